cpu_divide_seq: RTL and testbench

Multi-cycle sequencer for the execute stage's integer divide/modulo datapath (DIV_L, UDIV_L, MOD_L, UMOD_L). It accepts one request from the execute stage and runs a shared radix-2 restoring divider for 32 iterations. It holds the pipeline stalled while busy, then returns one registered writeback (index, enable, result) to the write stage.

---
 rtl/cpu_divide_seq.sv | 213 +++++++++++++++++++++
 tb/tb_cpu_divide_seq.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_divide_seq.sv
// Multi-cycle signed/unsigned divide and modulo sequencer (radix-2 restoring, WIDTH iterations).
// Optional build macro MOXIE_DIV_ZERO_TRAP_EN adds div_zero_o and suppresses writeback on a zero divisor.
module cpu_divide_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_sel_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic [3:0]       register_write_index_i,
    input  logic             flush_i,
`ifdef MOXIE_DIV_ZERO_TRAP_EN
    output logic             div_zero_o,
`endif
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic [3:0]       register_write_index_o,
    output logic             register_write_enable_o
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [3:0]       idx_q, idx_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       idx_out_q, idx_out_d;
    logic             done_q, done_d;
    logic             we_q, we_d;
`ifdef MOXIE_DIV_ZERO_TRAP_EN
    logic             dz_q, dz_d;
    logic             div_zero_q, div_zero_d;
`endif

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             is_signed;
    logic [WIDTH-1:0] mag_a, mag_b, q_fix, r_fix;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        idx_d     = idx_q;
        div_d     = div_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        result_d  = result_q;
        idx_out_d = idx_out_q;
        done_d    = done_q;
        we_d      = we_q;
`ifdef MOXIE_DIV_ZERO_TRAP_EN
        dz_d       = dz_q;
        div_zero_d = div_zero_q;
`endif

        // During PREP the raw operands sit in quo_q (dividend) and div_q (divisor).
        is_signed = ~op_q[0];
        mag_a     = (is_signed && quo_q[WIDTH-1]) ? (~quo_q + WIDTH'(1)) : quo_q;
        mag_b     = (is_signed && div_q[WIDTH-1]) ? (~div_q + WIDTH'(1)) : div_q;

        // Difference only kept when no borrow, so it always fits in WIDTH bits.
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        borrow = rem_sh < {1'b0, div_q};
        diff   = rem_sh[WIDTH-1:0] - div_q;

        q_fix = qneg_q ? (~quo_q + WIDTH'(1)) : quo_q;
        r_fix = rneg_q ? (~rem_q + WIDTH'(1)) : rem_q;

        unique case (state_q)
            IDLE: begin
                if (start_i && !flush_i) begin
                    op_d    = op_sel_i;
                    quo_d   = dividend_i;
                    div_d   = divisor_i;
                    idx_d   = register_write_index_i;
                    state_d = PREP;
                end
            end
            PREP: begin
                cnt_d = CNT_W'(WIDTH);
                rem_d = '0;
                if (div_q == '0) begin
                    quo_d  = '1;
                    rem_d  = quo_q;
                    qneg_d = 1'b0;
                    rneg_d = 1'b0;
`ifdef MOXIE_DIV_ZERO_TRAP_EN
                    dz_d = 1'b1;
`endif
                    state_d = FIX;
                end else begin
                    quo_d  = mag_a;
                    div_d  = mag_b;
                    qneg_d = is_signed & (quo_q[WIDTH-1] ^ div_q[WIDTH-1]);
                    rneg_d = is_signed & quo_q[WIDTH-1];
`ifdef MOXIE_DIV_ZERO_TRAP_EN
                    dz_d = 1'b0;
`endif
                    state_d = ITER;
                end
                if (flush_i) state_d = IDLE;
            end
            ITER: begin
                if (borrow) begin
                    rem_d = rem_sh[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end else begin
                    rem_d = diff;
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = FIX;
                if (flush_i) state_d = IDLE;
            end
            FIX: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    result_d  = op_q[1] ? r_fix : q_fix;
                    idx_out_d = idx_q;
                    done_d    = 1'b1;
`ifdef MOXIE_DIV_ZERO_TRAP_EN
                    we_d       = ~dz_q;
                    div_zero_d = dz_q;
`else
                    we_d = 1'b1;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d = 1'b0;
                we_d   = 1'b0;
`ifdef MOXIE_DIV_ZERO_TRAP_EN
                div_zero_d = 1'b0;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            idx_q     <= '0;
            div_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            result_q  <= '0;
            idx_out_q <= '0;
            done_q    <= 1'b0;
            we_q      <= 1'b0;
`ifdef MOXIE_DIV_ZERO_TRAP_EN
            dz_q       <= 1'b0;
            div_zero_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            idx_q     <= idx_d;
            div_q     <= div_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            result_q  <= result_d;
            idx_out_q <= idx_out_d;
            done_q    <= done_d;
            we_q      <= we_d;
`ifdef MOXIE_DIV_ZERO_TRAP_EN
            dz_q       <= dz_d;
            div_zero_q <= div_zero_d;
`endif
        end
    end

    assign stall_o = ((state_q == IDLE) && start_i) ||
                     (state_q == PREP) || (state_q == ITER) || (state_q == FIX);
    assign done_o                  = done_q;
    assign result_o                = result_q;
    assign register_write_index_o  = idx_out_q;
    assign register_write_enable_o = we_q;
`ifdef MOXIE_DIV_ZERO_TRAP_EN
    assign div_zero_o = div_zero_q;
`endif

endmodule

// File: tb/tb_cpu_divide_seq.sv
// Directed self-checking bench for cpu_divide_seq with hand-computed expected results.
module tb_cpu_divide_seq;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [1:0]  op_sel_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic [3:0]  register_write_index_i;
    logic        flush_i;
    logic        stall_o;
    logic        done_o;
    logic [31:0] result_o;
    logic [3:0]  register_write_index_o;
    logic        register_write_enable_o;
`ifdef MOXIE_DIV_ZERO_TRAP_EN
    logic        div_zero_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    cpu_divide_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk_i                  (clk_i),
        .rst_i                  (rst_i),
        .start_i                (start_i),
        .op_sel_i               (op_sel_i),
        .dividend_i             (dividend_i),
        .divisor_i              (divisor_i),
        .register_write_index_i (register_write_index_i),
        .flush_i                (flush_i),
`ifdef MOXIE_DIV_ZERO_TRAP_EN
        .div_zero_o             (div_zero_o),
`endif
        .stall_o                (stall_o),
        .done_o                 (done_o),
        .result_o               (result_o),
        .register_write_index_o (register_write_index_o),
        .register_write_enable_o(register_write_enable_o)
    );

    always #5 clk_i = ~clk_i;

    // Issues one request and waits (bounded) for done_o; samples 1 time unit after each edge.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] idx, output int edges, output logic [31:0] res,
                          output logic [3:0] ridx, output logic we, output logic dz,
                          output logic stall_busy_ok, output logic stall_done,
                          output logic done_next, output logic we_next);
        @(negedge clk_i);
        start_i = 1'b1; op_sel_i = op; dividend_i = a; divisor_i = b;
        register_write_index_i = idx;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        edges = 0; stall_busy_ok = 1'b1; res = '0; ridx = '0; we = 1'b0; dz = 1'b0;
        stall_done = 1'b1; done_next = 1'b1; we_next = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk_i); #1;
            edges++;
            if (done_o) break;
            if (!stall_o) stall_busy_ok = 1'b0;
        end
        if (done_o) begin
            res = result_o; ridx = register_write_index_o; we = register_write_enable_o;
            stall_done = stall_o;
`ifdef MOXIE_DIV_ZERO_TRAP_EN
            dz = div_zero_o;
`endif
            @(posedge clk_i); #1;
            done_next = done_o; we_next = register_write_enable_o;
        end else begin
            edges = 999;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_sel_i = '0;
        dividend_i = '0; divisor_i = '0; register_write_index_i = '0;
        #12;
        n_checks++;
        if ({stall_o, done_o, register_write_enable_o, result_o, register_write_index_o} !== 39'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got stall=%b done=%b we=%b res=%h idx=%h want all 0",
                     stall_o, done_o, register_write_enable_o, result_o, register_write_index_o);
        end
        @(negedge clk_i); rst_i = 1'b0;
    endtask

    task automatic test_udiv();
        int e; logic [31:0] r; logic [3:0] ix; logic we, dz, sb, sd, dn, wn;
        run_op(2'b01, 32'd100, 32'd7, 4'd3, e, r, ix, we, dz, sb, sd, dn, wn);
        n_checks++; if (e !== 34) begin n_fail++; $display("FAIL udiv_latency: got %0d want 34", e); end
        n_checks++; if (r !== 32'd14) begin n_fail++; $display("FAIL udiv_result: got %h want %h", r, 32'd14); end
        n_checks++; if (ix !== 4'd3) begin n_fail++; $display("FAIL udiv_index: got %0d want 3", ix); end
        n_checks++; if (we !== 1'b1) begin n_fail++; $display("FAIL udiv_we: got %b want 1", we); end
        n_checks++; if (sb !== 1'b1) begin n_fail++; $display("FAIL udiv_stall_busy: got %b want 1", sb); end
        n_checks++; if (sd !== 1'b0) begin n_fail++; $display("FAIL udiv_stall_done: got %b want 0", sd); end
        n_checks++;
        if ({dn, wn} !== 2'b00) begin
            n_fail++; $display("FAIL udiv_pulse_width: got done=%b we=%b next cycle want 0 0", dn, wn);
        end
        n_checks++; if (result_o !== 32'd14) begin n_fail++; $display("FAIL udiv_hold: got %h want %h", result_o, 32'd14); end
    endtask

    task automatic test_signed();
        logic [1:0]  ops [6] = '{2'b00, 2'b10, 2'b11, 2'b00, 2'b10, 2'b00};
        logic [31:0] as  [6] = '{32'hFFFFFF9C, 32'hFFFFFF9C, 32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'd100};
        logic [31:0] bs  [6] = '{32'd7, 32'd7, 32'd16, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9};
        logic [31:0] exp [6] = '{32'hFFFFFFF2, 32'hFFFFFFFE, 32'd15, 32'h80000000, 32'd0, 32'hFFFFFFF2};
        int e; logic [31:0] r; logic [3:0] ix; logic we, dz, sb, sd, dn, wn;
        for (int k = 0; k < 6; k++) begin
            run_op(ops[k], as[k], bs[k], 4'(k + 5), e, r, ix, we, dz, sb, sd, dn, wn);
            n_checks++;
            if (r !== exp[k] || e !== 34 || ix !== 4'(k + 5)) begin
                n_fail++;
                $display("FAIL signed_vec%0d: got res=%h lat=%0d idx=%0d want res=%h lat=34 idx=%0d",
                         k, r, e, ix, exp[k], k + 5);
            end
        end
    endtask

    task automatic test_div_zero();
        int e; logic [31:0] r; logic [3:0] ix; logic we, dz, sb, sd, dn, wn;
        run_op(2'b01, 32'd5, 32'd0, 4'd9, e, r, ix, we, dz, sb, sd, dn, wn);
        n_checks++; if (e !== 2) begin n_fail++; $display("FAIL dz_latency: got %0d want 2", e); end
        n_checks++; if (r !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL dz_udiv_result: got %h want ffffffff", r); end
`ifdef MOXIE_DIV_ZERO_TRAP_EN
        n_checks++; if ({dz, we} !== 2'b10) begin n_fail++; $display("FAIL dz_trap: got dz=%b we=%b want 1 0", dz, we); end
`else
        n_checks++; if (we !== 1'b1) begin n_fail++; $display("FAIL dz_we: got %b want 1", we); end
`endif
        run_op(2'b10, 32'hFFFFFF9C, 32'd0, 4'd9, e, r, ix, we, dz, sb, sd, dn, wn);
        n_checks++; if (r !== 32'hFFFFFF9C) begin n_fail++; $display("FAIL dz_mod_result: got %h want ffffff9c", r); end
    endtask

    task automatic test_flush();
        int e; logic [31:0] r; logic [3:0] ix; logic we, dz, sb, sd, dn, wn;
        logic saw_done;
        @(negedge clk_i);
        start_i = 1'b1; op_sel_i = 2'b01; dividend_i = 32'd100; divisor_i = 32'd7;
        register_write_index_i = 4'd2;
        @(posedge clk_i); #1; start_i = 1'b0;
        repeat (11) @(posedge clk_i);
        #1; flush_i = 1'b1;
        @(posedge clk_i); #1; flush_i = 1'b0;
        n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b want 0", stall_o); end
        saw_done = 1'b0;
        repeat (30) begin
            @(posedge clk_i); #1;
            if (done_o || register_write_enable_o) saw_done = 1'b1;
        end
        n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL flush_no_done: got %b want 0", saw_done); end
        run_op(2'b01, 32'd1000, 32'd10, 4'd4, e, r, ix, we, dz, sb, sd, dn, wn);
        n_checks++;
        if (r !== 32'd100 || e !== 34) begin
            n_fail++; $display("FAIL flush_restart: got res=%h lat=%0d want res=%h lat=34", r, e, 32'd100);
        end
        // Flush together with start in IDLE must not accept the request.
        @(negedge clk_i); start_i = 1'b1; flush_i = 1'b1;
        @(posedge clk_i); #1; start_i = 1'b0; flush_i = 1'b0;
        @(posedge clk_i); #1;
        n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL flush_start_idle: got stall=%b want 0", stall_o); end
    endtask

    task automatic test_back_to_back();
        int dones; logic [31:0] r;
        dones = 0; r = '0;
        @(negedge clk_i);
        start_i = 1'b1; op_sel_i = 2'b11; dividend_i = 32'd100; divisor_i = 32'd7;
        register_write_index_i = 4'd6;
        @(posedge clk_i); #1;
        op_sel_i = 2'b00; dividend_i = 32'd77; divisor_i = 32'd3;
        repeat (5) @(posedge clk_i);
        #1; start_i = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk_i); #1;
            if (done_o) begin dones++; r = result_o; end
        end
        n_checks++; if (dones !== 1) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 1", dones); end
        n_checks++; if (r !== 32'd2) begin n_fail++; $display("FAIL b2b_result: got %h want %h", r, 32'd2); end
    endtask

    task automatic test_async_reset();
        @(negedge clk_i);
        start_i = 1'b1; op_sel_i = 2'b01; dividend_i = 32'd50; divisor_i = 32'd5;
        register_write_index_i = 4'd1;
        @(posedge clk_i); #1; start_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #3; rst_i = 1'b1; #1;
        n_checks++;
        if ({stall_o, done_o, register_write_enable_o, result_o, register_write_index_o} !== 39'd0) begin
            n_fail++;
            $display("FAIL async_reset: got stall=%b done=%b we=%b res=%h idx=%h want all 0",
                     stall_o, done_o, register_write_enable_o, result_o, register_write_index_o);
        end
        @(negedge clk_i); rst_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_udiv();
        test_signed();
        test_div_zero();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
